// File: rtl/symb_chk_pkg.sv
// symb_chk_pkg: shared types, defaults and reference arithmetic for the
// symbolic-add response checker.
// Contents: state_t enum, default width constants, sat_add_s / wrap_add_u.
package symb_chk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_W          = 4;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_NUM_VEC    = 11;
  localparam int DEF_CW         = 8;

  // Signed sum of two w-bit two's-complement values, clamped to the w-bit
  // signed range. Inputs carry the raw w-bit patterns zero-extended; the
  // shift pair sign-extends them from bit w-1. Valid for 1 <= w <= 30.
  function automatic int sat_add_s(int a, int b, int w);
    int as;
    int bs;
    int sum;
    int hi;
    int lo;
    as  = (a <<< (32 - w)) >>> (32 - w);
    bs  = (b <<< (32 - w)) >>> (32 - w);
    sum = as + bs;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum;
  endfunction

  // Unsigned sum of two w-bit values, modulo 2^w.
  function automatic int wrap_add_u(int a, int b, int w);
    int mask;
    mask = (1 << w) - 1;
    return (a + b) & mask;
  endfunction

endpackage

// File: rtl/symb_add_checker_ref.sv
// symb_ref_model: combinational golden model of the block under test.
// Ports: d1, d2 (W-bit operands) -> exp_s (saturated signed sum),
//        exp_u (wrapping unsigned sum).
module symb_ref_model
  import symb_chk_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  output logic [W-1:0] exp_s,
  output logic [W-1:0] exp_u
);

  assign exp_s = W'(sat_add_s(int'(d1), int'(d2), W));
  assign exp_u = W'(wrap_add_u(int'(d1), int'(d2), W));

endmodule

// File: rtl/symb_add_checker.sv
// symb_add_checker: scores the block under test once its operands have been
// stable for SETTLE_CYC cycles; reports vec/err counts, first failing pair, pass.
// Ports: clk, rst (sync, active-high), start; d1/d2/signed_out/unsigned_out
//        observed; busy/done/pass/vec_cnt/err_cnt/err_d1/err_d2 reported.
// Optional: define SYMB_CHK_STOP_ON_ERR_EN to end the run at the first mismatch.
module symb_add_checker
  import symb_chk_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int NUM_VEC    = DEF_NUM_VEC,
  parameter int CW         = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  d1,
  input  logic [W-1:0]  d2,
  input  logic [W-1:0]  signed_out,
  input  logic [W-1:0]  unsigned_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] vec_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [W-1:0]  err_d1,
  output logic [W-1:0]  err_d2
);

  // Counter must be able to hold SETTLE_CYC on the cycle it leaves SETTLE.
  localparam int SCW = $clog2(SETTLE_CYC + 1);

  state_t          state;
  state_t          state_n;
  logic [2*W-1:0]  d_q;
  logic [SCW-1:0]  settle_cnt;
  logic [W-1:0]    exp_s;
  logic [W-1:0]    exp_u;
  logic            change;
  logic            mismatch;
  logic            stop_on_err;
  logic            clr_run;
  logic            do_check;
  logic [CW-1:0]   vec_nxt;

  symb_ref_model #(.W(W)) u_ref (
    .d1    (d1),
    .d2    (d2),
    .exp_s (exp_s),
    .exp_u (exp_u)
  );

  assign change   = ({d1, d2} != d_q);
  assign mismatch = (signed_out != exp_s) || (unsigned_out != exp_u);
  assign vec_nxt  = vec_cnt + CW'(1);

`ifdef SYMB_CHK_STOP_ON_ERR_EN
  assign stop_on_err = mismatch;
`else
  assign stop_on_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    clr_run  = 1'b0;
    do_check = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = SETTLE;
          clr_run = 1'b1;
        end
      end
      SETTLE: begin
        if (!change && (settle_cnt == SCW'(SETTLE_CYC - 1))) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        do_check = 1'b1;
        if ((vec_nxt == CW'(NUM_VEC)) || stop_on_err) begin
          state_n = DONE;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (change) begin
          state_n = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q        <= '0;
      settle_cnt <= '0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      err_d1     <= '0;
      err_d2     <= '0;
    end else begin
      d_q <= {d1, d2};
      if (clr_run) begin
        settle_cnt <= '0;
        vec_cnt    <= '0;
        err_cnt    <= '0;
        err_d1     <= '0;
        err_d2     <= '0;
      end else begin
        if (state == SETTLE) begin
          settle_cnt <= change ? '0 : settle_cnt + SCW'(1);
        end else if (state == WAIT) begin
          // Re-entry into SETTLE always starts a fresh window.
          settle_cnt <= '0;
        end
        if (do_check) begin
          vec_cnt <= vec_nxt;
          if (mismatch) begin
            if (err_cnt != '1) begin
              err_cnt <= err_cnt + CW'(1);
            end
            if (err_cnt == '0) begin
              err_d1 <= d1;
              err_d2 <= d2;
            end
          end
        end
      end
    end
  end

  assign busy = (state == SETTLE) || (state == CHECK) || (state == WAIT);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_symb_add_checker.sv
module tb_symb_add_checker;

  localparam int W          = 4;
  localparam int SETTLE_CYC = 4;
  localparam int NUM_VEC    = 3;
  localparam int CW         = 8;

`ifdef SYMB_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  d1;
  logic [W-1:0]  d2;
  logic [W-1:0]  signed_out;
  logic [W-1:0]  unsigned_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] vec_cnt;
  logic [CW-1:0] err_cnt;
  logic [W-1:0]  err_d1;
  logic [W-1:0]  err_d2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  symb_add_checker #(
    .W(W), .SETTLE_CYC(SETTLE_CYC), .NUM_VEC(NUM_VEC), .CW(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .d1           (d1),
    .d2           (d2),
    .signed_out   (signed_out),
    .unsigned_out (unsigned_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .vec_cnt      (vec_cnt),
    .err_cnt      (err_cnt),
    .err_d1       (err_d1),
    .err_d2       (err_d2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(string tag, int e_busy, int e_done, int e_pass,
                         int e_vec, int e_err, int e_d1, int e_d2);
    chk({tag, ".busy"},    int'(busy),    e_busy);
    chk({tag, ".done"},    int'(done),    e_done);
    chk({tag, ".pass"},    int'(pass),    e_pass);
    chk({tag, ".vec_cnt"}, int'(vec_cnt), e_vec);
    chk({tag, ".err_cnt"}, int'(err_cnt), e_err);
    chk({tag, ".err_d1"},  int'(err_d1),  e_d1);
    chk({tag, ".err_d2"},  int'(err_d2),  e_d2);
  endtask

  // Drive one operand pair plus the block-under-test results and hold for
  // 10 cycles. A scored vector lands in vec_cnt on the 6th edge after the
  // drive (1 edge to register the change, SETTLE_CYC settle cycles, 1 CHECK).
  task automatic apply_vec(string tag, int a, int b, int s, int u, bit st,
                           int pre, int post);
    d1           = W'(a);
    d2           = W'(b);
    signed_out   = W'(s);
    unsigned_out = W'(u);
    start        = st;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk({tag, ".pre"}, int'(vec_cnt), pre);
    tick();
    chk({tag, ".post"}, int'(vec_cnt), post);
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    d1 = '0; d2 = '0; signed_out = '0; unsigned_out = '0;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_out("idle", 0, 0, 0, 0, 0, 0, 0);

    // Clean run; start during the second vector is ignored (busy).
    apply_vec("t1v0", 1, 1, 2, 2,  1'b1, 0, 1);
    apply_vec("t1v1", 2, 1, 3, 3,  1'b1, 1, 2);
    apply_vec("t1v2", 7, 4, 7, 11, 1'b0, 2, 3);
    chk_out("t1_end", 0, 1, 1, 3, 0, 0, 0);

    // Faulty unsigned result on (2,1).
    apply_vec("t2v0", 1, 1, 2, 2,  1'b1, 0, 1);
    apply_vec("t2v1", 2, 1, 3, 0,  1'b0, 1, 2);
    apply_vec("t2v2", 7, 4, 7, 11, 1'b0, 2, STOP ? 2 : 3);
    chk_out("t2_end", 0, 1, 0, STOP ? 2 : 3, 1, 2, 1);

    // Operands toggling every 3 cycles never settle.
    for (int i = 0; i < 10; i++) begin
      d1           = (i % 2 == 1) ? W'(2) : W'(1);
      d2           = d1;
      signed_out   = d1 + d1;
      unsigned_out = d1 + d1;
      start        = (i == 0);
      tick();
      start = 1'b0;
      tick();
      tick();
    end
    chk("t3.busy",    int'(busy),    1);
    chk("t3.done",    int'(done),    0);
    chk("t3.vec_cnt", int'(vec_cnt), 0);

    // Saturating signed results scored correctly (run continues from t3).
    apply_vec("t4v0", 7, 4,  7, 11, 1'b0, 0, 1);
    apply_vec("t4v1", 4, 6,  7, 10, 1'b0, 1, 2);
    apply_vec("t4v2", 8, 15, 8, 7,  1'b0, 2, 3);
    chk_out("t4_end", 0, 1, 1, 3, 0, 0, 0);

    // Wrapped signed results must be flagged.
    apply_vec("t4w0", 7, 4,  11, 11, 1'b1, 0, 1);
    apply_vec("t4w1", 4, 6,  10, 10, 1'b0, 1, STOP ? 1 : 2);
    apply_vec("t4w2", 8, 15, 7,  7,  1'b0, STOP ? 1 : 2, STOP ? 1 : 3);
    chk_out("t4w_end", 0, 1, 0, STOP ? 1 : 3, STOP ? 1 : 3, 7, 4);

    // Reset in SETTLE after one checked vector, then a clean run.
    apply_vec("t5v0", 1, 1, 2, 2, 1'b1, 0, 1);
    d1 = W'(2); d2 = W'(1); signed_out = W'(3); unsigned_out = W'(3);
    tick();
    tick();
    chk("t5.settle_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk_out("t5_rst", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    apply_vec("t5r0", 1, 1, 2, 2,  1'b1, 0, 1);
    apply_vec("t5r1", 2, 1, 3, 3,  1'b0, 1, 2);
    apply_vec("t5r2", 7, 4, 7, 11, 1'b0, 2, 3);
    chk_out("t5_end", 0, 1, 1, 3, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/symb_add_checker.md
Name: symb_add_checker

Overview:
- Synthesizable response checker that sits on the far side of the symbolic-arithmetic block under test.
- It watches the operand pair driven into that block (d1, d2) and the block's two results (signed_out, unsigned_out).
- Once the operands have been stable for a settle window, it computes the expected results and scores them.
- It reports vector count, error count, first failing vector and pass/fail, so the filter-arithmetic primitives can be self-checked on hardware without a simulator.

Parameters:
- W, 4, operand and result width in bits.
- SETTLE_CYC, 8, cycles operands must stay unchanged before a check (min 1).
- NUM_VEC, 11, number of checked vectors that ends a run (min 1).
- CW, 8, width of the vec_cnt and err_cnt counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run.
- d1  in  W  operand A as driven into the block under test.
- d2  in  W  operand B as driven into the block under test.
- signed_out  in  W  block-under-test signed result.
- unsigned_out  in  W  block-under-test unsigned result.
- busy  out  1  run in progress.
- done  out  1  run finished; held high.
- pass  out  1  done and err_cnt==0.
- vec_cnt  out  CW  number of vectors checked.
- err_cnt  out  CW  number of mismatching vectors; saturates at all-ones.
- err_d1  out  W  d1 of the first failing vector.
- err_d2  out  W  d2 of the first failing vector.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Every register clears on rst. All outputs reset to 0 and the state resets to IDLE.
- Operand tracking: {d1,d2} is registered every cycle into d_q. A "change" is {d1,d2} != d_q in the current cycle.
- Reference model:
  - exp_u = (d1+d2) mod 2^W.
  - exp_s = two's-complement sum of d1 and d2 computed at W+1 bits, clamped to [-2^(W-1), 2^(W-1)-1]. With W=4: 7+4 gives 7; 4+6 gives 7; -8+-1 gives -8.
- A vector mismatches if signed_out != exp_s OR unsigned_out != exp_u. Both comparisons are sampled in the CHECK cycle.
- States:
  - IDLE: busy=0. start goes to SETTLE; on entry it clears vec_cnt, err_cnt, err_d1, err_d2, done, pass and the settle counter.
  - SETTLE: the settle counter increments each cycle and is cleared on any change. When the counter equals SETTLE_CYC-1 and there is no change that cycle, go to CHECK.
  - CHECK (exactly one cycle):
    - vec_cnt increments.
    - On mismatch, err_cnt increments (saturating), and if err_cnt was 0, err_d1/err_d2 capture the current d1/d2.
    - If the new vec_cnt == NUM_VEC, go to DONE; otherwise go to WAIT.
  - WAIT: hold until a change, then go to SETTLE with the counter at 0. A static operand pair is scored once only.
  - DONE: busy=0, done=1, pass=(err_cnt==0). A start pulse restarts exactly as from IDLE.
- Settle latency: the check occurs SETTLE_CYC cycles after the first cycle with no change.
- start while busy is ignored.
- rst mid-run aborts to IDLE immediately, with all counters and outputs at 0.
- Operands that change in the same cycle the counter reaches SETTLE_CYC-1 restart the settle window; no check occurs that cycle.
- vec_cnt never exceeds NUM_VEC.

Optional Feature:
- SYMB_CHK_STOP_ON_ERR_EN defined: the first mismatch in CHECK forces DONE after that cycle, regardless of vec_cnt. Result: err_cnt=1, pass=0.
- Not defined: the run always completes all NUM_VEC vectors.

Decomposition:
- Package symb_chk_pkg holds:
  - state enum (IDLE, SETTLE, CHECK, WAIT, DONE);
  - default width constants;
  - function sat_add_s(a, b, W) and function wrap_add_u(a, b, W).
- One sub-module, symb_ref_model: combinational; takes d1/d2 and produces exp_s/exp_u. It is instantiated by the checker and reusable by testbenches.

Test Plan:
- W=4, SETTLE_CYC=4, NUM_VEC=3, correct DUT model. Pairs (1,1), (2,1), (7,4), each held 10 cycles. Expected: done=1, pass=1, vec_cnt=3, err_cnt=0.
- Same stimulus with the DUT model reporting unsigned_out=0 for (2,1). Expected: err_cnt=1, err_d1=2, err_d2=1, pass=0.
- Operands toggling every 3 cycles with SETTLE_CYC=4. Expected: vec_cnt stays 0 and the state stays SETTLE.
- Saturation: (7,4) with signed_out=7; (4,6) with signed_out=7; (8,15), i.e. -8+-1, with signed_out=8 (-8). Expected: no errors. The same vectors with a wrapped signed result (11) are flagged.
- rst asserted in SETTLE after 1 vector is checked. Expected: all outputs 0 the next cycle; start then gives a clean run from vec_cnt=0.
- SYMB_CHK_STOP_ON_ERR_EN defined, NUM_VEC=5, mismatch on vector 2. Expected: done asserted after vector 2, vec_cnt=2, err_cnt=1.
